mem_stage_lsu: RTL
==================

# mem_stage_lsu

Parametrised load/store unit for the MEM stage of the five-stage pipeline; it is the successor to the single-cycle data-memory stage. It holds a word-organised data memory with true byte-lane stores, so SB/SH preserve the untouched bytes. It decodes RISC-V funct3 for all five load and three store widths, flags misaligned and illegal accesses, and supports a configurable number of wait states with a stall output to the hazard unit.

## Interface
- DEPTH, 32, number of 32-bit words; power of two, 4..1024
- WAIT_STATES, 0, extra cycles per access; 0..15
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- EXMEM_MemoryRead  in  1  load request
- EXMEM_MemoryWrite  in  1  store request
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- EXMEM_AluRES  in  32  byte address
- rs2  in  32  store data; the byte/half is taken from the LSBs
- EXMEM_LoadData  out  32  extended load result
- load_valid  out  1  one-cycle pulse when EXMEM_LoadData is new
- mem_stall  out  1  high while an access is in progress; the pipeline must freeze
- mem_fault  out  1  one-cycle pulse for a misaligned or illegal access

## Operation
- Word index = EXMEM_AluRES[$clog2(DEPTH)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH*4. Lane = EXMEM_AluRES[1:0].
- Request = Read | Write, sampled only in state IDLE. If both are high, the request is a store; no load_valid is produced.
- Fault conditions:
  - H/HU with addr[0]=1
  - W with addr[1:0]≠0
  - funct3 011, 110 or 111 on a load
  - funct3 ≥ 011 on a store
- A faulting request performs no memory access. mem_fault pulses at the completion edge, load_valid stays 0, and EXMEM_LoadData goes to 0.
- Store byte: writes byte lane `lane`; the other three bytes are unchanged.
- Store half: writes half-word lane addr[1]; the other half is unchanged.
- Store word: writes the whole word.
- LB/LH sign-extend and LBU/LHU zero-extend the selected lane; LW returns the whole word.
- FSM states and transitions:
  - IDLE: a request moves to BUSY if WAIT_STATES>0. Otherwise the access completes at the accepting edge and the FSM stays in IDLE.
  - BUSY: a counter loads WAIT_STATES-1 and decrements each cycle; at 0 the FSM goes to DONE.
  - DONE: performs the access, pulses load_valid or mem_fault, and returns to IDLE.
- Request fields (address, data, funct3, kind) are latched at acceptance. Input changes while mem_stall=1 are ignored.
- Reset zeroes all DEPTH words, returns the FSM to IDLE, and drives all outputs to 0.

## Timing
- All outputs are registered. Reset values: EXMEM_LoadData=0, load_valid=0, mem_stall=0, mem_fault=0.
- WAIT_STATES=0:
  - A request sampled at edge N completes at edge N. Results are visible in cycle N+1. mem_stall is never asserted.
  - Back-to-back accesses are possible every cycle.
  - A load issued the cycle after a store to the same word returns the new data.
- WAIT_STATES=W>0:
  - mem_stall rises at the accept edge and falls at the completion edge, which comes W+1 edges later; it is high for W+1 cycles.
  - The store write, load_valid and mem_fault occur at the completion edge.
  - The next request is sampled no earlier than the completion edge +1.
- EXMEM_LoadData holds its last value between loads and is updated only by a load completion or a fault.
- Reset mid-access abandons the access: no write, no pulse, and mem_stall drops at the reset edge.
- Idle cycles (no request) leave the memory and EXMEM_LoadData unchanged.

## Test plan
- W=0, SW 0xDEADBEEF to address 0x8, then LW 0x8 → EXMEM_LoadData=0xDEADBEEF with a one-cycle load_valid pulse. LB 0x8 → 0xFFFFFFEF. LBU 0xB → 0x000000DE.
- W=0, SW 0x11223344 to 0x10, then SB 0xAA to 0x11, then SH 0xBBCC to 0x12, then LW 0x10 → 0xBBCCAA44. LH 0x12 → 0xFFFFBBCC. LHU 0x12 → 0x0000BBCC.
- Faults: LW 0x6 → mem_fault=1, load_valid=0, EXMEM_LoadData=0. SH to 0x3 → mem_fault=1 and the word at 0x0 is unchanged. funct3=011 load → mem_fault=1.
- WAIT_STATES=3, LW issued at edge N → mem_stall=1 for cycles N+1..N+4, load_valid at edge N+4. A request toggled while stalled is ignored.
- DEPTH=32: SW 0x5A5A5A5A to 0x80 aliases to word 0, so LW 0x0 returns 0x5A5A5A5A. Read and Write both high → store performed, no load_valid.
- WAIT_STATES=2, SW 0x1 to 0x4 with rst asserted one cycle after acceptance → mem_stall=0 after the reset edge and LW 0x4 returns 0. After the first reset all 32 words read 0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: word-organised data memory with byte-lane
// stores, funct3 width decode with sign/zero extension, misaligned/illegal
// access detection and a configurable number of wait states that hold
// mem_stall high while an access is outstanding.
module mem_stage_lsu #(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXMEM_MemoryRead,
    input  logic        EXMEM_MemoryWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] EXMEM_AluRES,
    input  logic [31:0] rs2,
    output logic [31:0] EXMEM_LoadData,
    output logic        load_valid,
    output logic        mem_stall,
    output logic        mem_fault
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam bit          NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0]  CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [31:0] mem [DEPTH];

    // Request fields captured at acceptance
    logic [AW+1:0] req_addr;
    logic [31:0]   req_data;
    logic [2:0]    req_f3;
    logic          req_store;
    logic [3:0]    cnt;

    // Fields of the access currently being performed
    logic          req_in;
    logic          accept;
    logic          complete;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_data;
    logic [2:0]    acc_f3;
    logic          acc_store;
    logic [AW-1:0] acc_idx;
    logic [1:0]    acc_lane;
    logic          acc_fault;

    logic [31:0] rd_word;
    logic [31:0] wr_word;
    logic [31:0] load_ext;

    // Next values of the registered outputs
    logic [31:0] ld_d;
    logic        lv_d;
    logic        mf_d;
    logic        stall_d;

    // Address bits above the memory size only wrap; they carry no meaning
    logic unused_addr_hi;
    assign unused_addr_hi = ^EXMEM_AluRES[31:AW+2];

    assign req_in = EXMEM_MemoryRead | EXMEM_MemoryWrite;
    assign accept = (state == S_IDLE) && req_in;

    // Zero wait states complete at the accepting edge using live inputs;
    // otherwise the access is performed from the latched copy in DONE.
    assign complete = (NO_WAIT && accept) || (state == S_DONE);

    // Select between live inputs (IDLE) and the latched request
    always_comb begin
        if (state == S_IDLE) begin
            acc_addr  = EXMEM_AluRES[AW+1:0];
            acc_data  = rs2;
            acc_f3    = funct3;
            acc_store = EXMEM_MemoryWrite;
        end else begin
            acc_addr  = req_addr;
            acc_data  = req_data;
            acc_f3    = req_f3;
            acc_store = req_store;
        end
    end

    assign acc_idx  = acc_addr[AW+1:2];
    assign acc_lane = acc_addr[1:0];
    assign rd_word  = mem[acc_idx];

    // Illegal width encodings and misalignment detection
    always_comb begin
        acc_fault = 1'b0;
        if (acc_store) begin
            if (acc_f3[2] || (acc_f3 == 3'b011))
                acc_fault = 1'b1;
        end else begin
            if ((acc_f3 == 3'b011) || (acc_f3 == 3'b110) || (acc_f3 == 3'b111))
                acc_fault = 1'b1;
        end
        if ((acc_f3[1:0] == 2'b01) && acc_lane[0])
            acc_fault = 1'b1;
        if ((acc_f3[1:0] == 2'b10) && (acc_lane != 2'b00))
            acc_fault = 1'b1;
    end

    // Merge store data into the addressed word, preserving untouched lanes
    always_comb begin
        wr_word = rd_word;
        case (acc_f3[1:0])
            2'b00:   wr_word[{acc_lane, 3'b000} +: 8]     = acc_data[7:0];
            2'b01:   wr_word[{acc_lane[1], 4'b0000} +: 16] = acc_data[15:0];
            default: wr_word = acc_data;
        endcase
    end

    // Lane select and sign/zero extension for loads
    always_comb begin
        logic [7:0]  sel_b;
        logic [15:0] sel_h;
        sel_b = rd_word[{acc_lane, 3'b000} +: 8];
        sel_h = rd_word[{acc_lane[1], 4'b0000} +: 16];
        case (acc_f3)
            F3_B:    load_ext = {{24{sel_b[7]}}, sel_b};
            F3_H:    load_ext = {{16{sel_h[15]}}, sel_h};
            F3_W:    load_ext = rd_word;
            F3_BU:   load_ext = {24'd0, sel_b};
            F3_HU:   load_ext = {16'd0, sel_h};
            default: load_ext = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req_in && !NO_WAIT) state_next = S_BUSY;
            S_BUSY:  if (cnt == 4'd0) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs
    always_comb begin
        ld_d    = EXMEM_LoadData;
        lv_d    = 1'b0;
        mf_d    = 1'b0;
        stall_d = (state_next != S_IDLE);
        if (complete) begin
            if (acc_fault) begin
                mf_d = 1'b1;
                ld_d = '0;
            end else if (!acc_store) begin
                lv_d = 1'b1;
                ld_d = load_ext;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            EXMEM_LoadData <= '0;
            load_valid     <= 1'b0;
            mem_fault      <= 1'b0;
            mem_stall      <= 1'b0;
        end else begin
            EXMEM_LoadData <= ld_d;
            load_valid     <= lv_d;
            mem_fault      <= mf_d;
            mem_stall      <= stall_d;
        end
    end

    // Request capture at acceptance and wait-state countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr  <= '0;
            req_data  <= '0;
            req_f3    <= '0;
            req_store <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            req_addr  <= EXMEM_AluRES[AW+1:0];
            req_data  <= rs2;
            req_f3    <= funct3;
            req_store <= EXMEM_MemoryWrite;
            cnt       <= CNT_INIT;
        end else if ((state == S_BUSY) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Data memory: cleared on reset, written on a fault-free store completion
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[AW'(i)] <= '0;
        end else if (complete && acc_store && !acc_fault) begin
            mem[acc_idx] <= wr_word;
        end
    end

endmodule
